// File: rtl/pkt_fifo_v2.sv
// Per-port ingress packet FIFO: parametrised width/depth, FWFT or registered read,
// threshold flags, occupancy count, sticky error flags and synchronous flush.
module pkt_fifo_v2 #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int FWFT       = 0,
   parameter int AF_THRESH  = DEPTH - 1,
   parameter int AE_THRESH  = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic                         wr_en,
   output logic                         fifo_full,
   output logic                         almost_full,
   input  logic                         rd_en,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         data_valid,
   output logic                         fifo_empty,
   output logic                         almost_empty,
   output logic [DATA_WIDTH/2-1:0]      header_out,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         overflow,
   output logic                         underflow,
   input  logic                         clr_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH + 1);
   localparam int HW = DATA_WIDTH / 2;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  ovf_set;
   logic                  unf_set;

   // Explicit wrap so non-power-of-2 depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign fifo_full    = (level == LW'(DEPTH));
   assign fifo_empty   = (level == '0);
   assign almost_full  = (int'(level) >= AF_THRESH);
   assign almost_empty = (int'(level) <= AE_THRESH);

   assign wr_acc  = wr_en & ~fifo_full  & ~flush;
   assign rd_acc  = rd_en & ~fifo_empty & ~flush;
   assign ovf_set = wr_en & fifo_full  & ~flush;
   assign unf_set = rd_en & fifo_empty & ~flush;

   assign header_out = fifo_empty ? '0 : mem[rd_ptr][HW-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
         case ({wr_acc, rd_acc})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // A new error in the same cycle as clr_err wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= ovf_set | (overflow  & ~clr_err);
         underflow <= unf_set | (underflow & ~clr_err);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= data_in;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out   = mem[rd_ptr];
         assign data_valid = ~fifo_empty;
      end else begin : g_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               data_out   <= '0;
               data_valid <= 1'b0;
            end else if (flush) begin
               data_valid <= 1'b0;
            end else begin
               data_valid <= rd_acc;
               if (rd_acc) data_out <= mem[rd_ptr];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_pkt_fifo_v2.sv
// Bench for pkt_fifo_v2: a DEPTH=8 registered-read instance and a DEPTH=5 FWFT instance
// against a ring-buffer reference model with a read-data scoreboard.
module tb_pkt_fifo_v2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] din  [2];
   logic        wr   [2];
   logic        rd   [2];
   logic        fl   [2];
   logic        ce   [2];
   logic [15:0] dout [2];
   logic        dv   [2];
   logic        full [2];
   logic        empty[2];
   logic        af   [2];
   logic        ae   [2];
   logic        ovf  [2];
   logic        unf  [2];
   logic [7:0]  hdr  [2];
   logic [3:0]  lvl0;
   logic [2:0]  lvl1;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] mm [2][8];
   int          mh [2];
   int          mc [2];
   logic        oflg [2];
   logic        uflg [2];
   logic [15:0] exp_q [$];
   logic [15:0] last0;
   int          dep  [2] = '{8, 5};
   int          afth [2] = '{6, 4};

   always #5 clk = ~clk;

   pkt_fifo_v2 #(.DATA_WIDTH(16), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1)) u0 (
      .clk(clk), .rst_n(rst_n), .flush(fl[0]), .data_in(din[0]), .wr_en(wr[0]),
      .fifo_full(full[0]), .almost_full(af[0]), .rd_en(rd[0]), .data_out(dout[0]),
      .data_valid(dv[0]), .fifo_empty(empty[0]), .almost_empty(ae[0]), .header_out(hdr[0]),
      .level(lvl0), .overflow(ovf[0]), .underflow(unf[0]), .clr_err(ce[0])
   );

   pkt_fifo_v2 #(.DATA_WIDTH(16), .DEPTH(5), .FWFT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .flush(fl[1]), .data_in(din[1]), .wr_en(wr[1]),
      .fifo_full(full[1]), .almost_full(af[1]), .rd_en(rd[1]), .data_out(dout[1]),
      .data_valid(dv[1]), .fifo_empty(empty[1]), .almost_empty(ae[1]), .header_out(hdr[1]),
      .level(lvl1), .overflow(ovf[1]), .underflow(unf[1]), .clr_err(ce[1])
   );

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < 2; i++) begin
         mc[i] = 0; mh[i] = 0; oflg[i] = 1'b0; uflg[i] = 1'b0;
      end
      last0 = 16'h0;
      exp_q.delete();
   endtask

   task automatic chk_state(input int i, input logic dv_exp);
      logic [15:0] hw;
      logic [31:0] lv;
      logic        e;
      lv = (i == 0) ? 32'(lvl0) : 32'(lvl1);
      hw = (mc[i] > 0) ? mm[i][mh[i]] : 16'h0;
      e  = (i == 0) ? dv_exp : (mc[1] > 0);
      chk("level",        i, lv,       mc[i]);
      chk("fifo_full",    i, full[i],  mc[i] == dep[i]);
      chk("fifo_empty",   i, empty[i], mc[i] == 0);
      chk("almost_full",  i, af[i],    mc[i] >= afth[i]);
      chk("almost_empty", i, ae[i],    mc[i] <= 1);
      chk("header_out",   i, hdr[i],   hw[7:0]);
      chk("overflow",     i, ovf[i],   oflg[i]);
      chk("underflow",    i, unf[i],   uflg[i]);
      chk("data_valid",   i, dv[i],    e);
      if (i == 0) begin
         if (dv_exp) last0 = exp_q.pop_front();
         chk("data_out", 0, dout[0], last0);
      end else if (mc[1] > 0) begin
         chk("data_out", 1, dout[1], mm[1][mh[1]]);
      end
   endtask

   task automatic step(input int i, input logic w, input logic r, input logic [15:0] d,
                       input logic f, input logic c);
      logic ow, uw, racc, wacc, dve;
      din[i] = d; wr[i] = w; rd[i] = r; fl[i] = f; ce[i] = c;
      ow = 1'b0; uw = 1'b0; dve = 1'b0;
      if (f) begin
         mc[i] = 0; mh[i] = 0;
      end else begin
         ow   = w && (mc[i] == dep[i]);
         uw   = r && (mc[i] == 0);
         racc = r && (mc[i] > 0);
         wacc = w && (mc[i] < dep[i]);
         if (racc) begin
            if (i == 0) exp_q.push_back(mm[i][mh[i]]);
            mh[i] = (mh[i] + 1) % dep[i];
            mc[i]--;
            dve = 1'b1;
         end
         if (wacc) begin
            mm[i][(mh[i] + mc[i]) % dep[i]] = d;
            mc[i]++;
         end
      end
      oflg[i] = ow | (oflg[i] & !c);
      uflg[i] = uw | (uflg[i] & !c);
      @(posedge clk);
      #1;
      wr[i] = 1'b0; rd[i] = 1'b0; fl[i] = 1'b0; ce[i] = 1'b0;
      chk_state(i, dve);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         din[i] = 16'h0; wr[i] = 1'b0; rd[i] = 1'b0; fl[i] = 1'b0; ce[i] = 1'b0;
      end
      reset_model();
      #12;
      chk_state(0, 1'b0);
      chk_state(1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // fill and drain the depth-8 registered-read FIFO
      for (int k = 1; k <= 8; k++) step(0, 1'b1, 1'b0, 16'(k * 257), 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) step(0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
      step(0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

      // underflow on a bare read, then clear
      step(0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
      step(0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

      // full with simultaneous read/write
      for (int k = 1; k <= 8; k++) step(0, 1'b1, 1'b0, 16'(16'h1000 + k), 1'b0, 1'b0);
      step(0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
      step(0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      step(0, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
      step(0, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b1);
      step(0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      for (int k = 0; k < 8 && mc[0] > 0; k++) step(0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);

      // empty with simultaneous read/write, both read modes
      step(0, 1'b1, 1'b1, 16'h00A5, 1'b0, 1'b0);
      step(0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b1);
      step(1, 1'b1, 1'b1, 16'h00A5, 1'b0, 1'b0);
      step(1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      step(1, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);

      // depth-5 pointer wrap over three rounds
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 4; k++) step(1, 1'b1, 1'b0, 16'(16'h5000 + r * 16 + k), 1'b0, 1'b0);
         for (int k = 0; k < 4; k++) step(1, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
      end
      for (int k = 0; k < 6; k++) step(1, 1'b1, 1'b0, 16'(16'h6000 + k), 1'b0, 1'b0);
      step(1, 1'b0, 1'b1, 16'h0, 1'b1, 1'b0);
      step(1, 1'b1, 1'b0, 16'h6A6A, 1'b0, 1'b1);

      // flush with a concurrent write
      for (int k = 0; k < 3; k++) step(0, 1'b1, 1'b0, 16'(16'h7000 + k), 1'b0, 1'b0);
      step(0, 1'b1, 1'b0, 16'hDEAD, 1'b1, 1'b0);
      step(0, 1'b0, 1'b1, 16'h0, 1'b1, 1'b0);

      // asynchronous reset in the middle of a burst
      step(0, 1'b1, 1'b0, 16'h3333, 1'b0, 1'b0);
      step(0, 1'b1, 1'b1, 16'h3434, 1'b0, 1'b0);
      din[0] = 16'h4444;
      wr[0]  = 1'b1;
      #2;
      rst_n = 1'b0;
      reset_model();
      #1;
      chk_state(0, 1'b0);
      chk_state(1, 1'b0);
      wr[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 1'b1, 1'b0, 16'h7777, 1'b0, 1'b0);
      step(0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
      step(0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pkt_fifo_v2.md
Name: pkt_fifo_v2

Overview:
Parametrised successor to the switch's per-port input FIFO. It adds configurable width and depth (non-power-of-2 allowed), a selectable first-word-fall-through (FWFT) or registered-read mode, almost-full/almost-empty thresholds, an occupancy output, sticky overflow/underflow error flags and a synchronous flush. It sits between each port's ingress and the packet parser/arbiter. The header peek stays available regardless of grant.

Parameters:
DATA_WIDTH, 16, word width; must be even, >= 4
DEPTH, 8, storage words; any integer >= 2, power of 2 not required
FWFT, 0, 0 = registered read (1-cycle latency), 1 = first-word fall-through
AF_THRESH, DEPTH-1, almost_full asserts when level >= AF_THRESH
AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of contents
data_in  in  DATA_WIDTH  write data
wr_en  in  1  write request
fifo_full  out  1  level == DEPTH
almost_full  out  1  level >= AF_THRESH
rd_en  in  1  read request
data_out  out  DATA_WIDTH  read data
data_valid  out  1  data_out holds a valid popped/head word
fifo_empty  out  1  level == 0
almost_empty  out  1  level <= AE_THRESH
header_out  out  DATA_WIDTH/2  head word bits [DATA_WIDTH/2-1:0]; 0 when empty
level  out  $clog2(DEPTH+1)  current stored word count
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  clears overflow/underflow

Behaviour:
- Reset (async, rst_n=0): pointers=0, level=0, data_out=0, data_valid=0, overflow=0, underflow=0. Outputs: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=(AF_THRESH==0), header_out=0. Reset mid-transfer discards all contents immediately.
- Pointers wrap explicitly: ptr==DEPTH-1 -> 0. No reliance on natural binary overflow.
- Accept rules use the flags registered at the clock edge:
  - wr_acc = wr_en & !fifo_full
  - rd_acc = rd_en & !fifo_empty
- Full with wr_en and rd_en: read accepted, write rejected, overflow set, level -> DEPTH-1.
- Empty with wr_en and rd_en: write accepted, read rejected, underflow set, level -> 1. No bypass.
- Both accepted: level unchanged, both pointers advance.
- level updates +1, -1 or 0 per cycle. Flags are combinational from level.
- FWFT=0: on rd_acc, data_out <= mem[rd_ptr] and data_valid=1 for that one following cycle, else 0. data_out holds its last value when no read occurs.
- FWFT=1: data_out = mem[rd_ptr] combinationally; data_valid = !fifo_empty; rd_acc pops the word.
- header_out = head word low half when !fifo_empty, else 0. Independent of rd_en.
- overflow/underflow are sticky until clr_err=1 or reset. If clr_err and a new error occur in the same cycle, the flag stays set.
- flush=1: next edge sets pointers=0 and level=0; data_valid <= 0 in FWFT=0. Flush has priority: a same-cycle wr/rd is ignored and no error flags are set. data_out holds its value in FWFT=0.
- Memory contents are not reset. Only pointers qualify validity.

Test Plan:
- DEPTH=8, FWFT=0: write 0x0101..0x0808 -> fifo_full=1, level=8. Read 8 -> data_out 0x0101..0x0808, each 1 cycle after rd_en, data_valid pulses. Ends fifo_empty=1.
- DEPTH=5: 3 rounds of write 4 / read 4 -> pointers wrap past 4->0. Data order is preserved and level never exceeds 4.
- Full with wr_en=rd_en=1 and data_in=0xBEEF -> head popped, 0xBEEF not stored, overflow=1, level=DEPTH-1. Then clr_err -> overflow=0.
- Empty with wr_en=rd_en=1 and data_in=0x00A5 -> level=1, underflow=1, header_out=0xA5 next cycle. With FWFT=1, data_out=0x00A5 and data_valid=1.
- AF_THRESH=6, AE_THRESH=1, DEPTH=8: fill -> almost_full rises at level=6. Drain -> almost_empty rises at level=1.
- Write 3 words, then assert flush together with wr_en -> level=0, fifo_empty=1, no overflow. Assert rst_n=0 mid-burst -> all outputs go to reset values asynchronously.
